// File: rtl/tdp_bist_pkg.sv
// Shared types and the data-pattern generator for the TDP BRAM self-test.
package tdp_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PAT_MAX_A = 32;
  localparam int PAT_MAX_D = 512;

  // Address replicated LSB-first across dbits, optionally inverted; caller truncates to its width.
  function automatic logic [PAT_MAX_D-1:0] pat(input logic [PAT_MAX_A-1:0] addr,
                                               input logic inv,
                                               input int abits,
                                               input int dbits);
    logic [PAT_MAX_D-1:0] r;
    r = '0;
    for (int i = 0; i < PAT_MAX_D; i++)
      if (i < dbits) r[i] = addr[i % abits] ^ inv;
    return r;
  endfunction

endpackage

// File: rtl/tdp_bram_bist_if.sv
// Two-port BRAM bus: address, write data, write enable and 1-cycle-latency read data per port.
interface tdp_bram_bist_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 36
);
  logic [ABITS-1:0] a_a;
  logic [DBITS-1:0] wd_a;
  logic             we_a;
  logic [DBITS-1:0] rd_a;
  logic [ABITS-1:0] a_b;
  logic [DBITS-1:0] wd_b;
  logic             we_b;
  logic [DBITS-1:0] rd_b;

  modport master (output a_a, wd_a, we_a, a_b, wd_b, we_b, input rd_a, rd_b);
  modport slave  (input a_a, wd_a, we_a, a_b, wd_b, we_b, output rd_a, rd_b);
endinterface

// File: rtl/tdp_bist_checker.sv
// Read-back comparator for both ports: registers expectations, compares a cycle later, latches first failure.
module tdp_bist_checker #(
  parameter int ABITS = 10,
  parameter int DBITS = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue,
  input  logic [DBITS-1:0] exp_a,
  input  logic [ABITS-1:0] addr_a,
  input  logic [DBITS-1:0] exp_b,
  input  logic [ABITS-1:0] addr_b,
  input  logic [DBITS-1:0] rd_a,
  input  logic [DBITS-1:0] rd_b,
  output logic             mis,
  output logic             sticky,
  output logic [ABITS-1:0] fail_addr
);
  logic             vld_q;
  logic [DBITS-1:0] exp_a_q, exp_b_q;
  logic [ABITS-1:0] addr_a_q, addr_b_q;
  logic             mis_a, mis_b;

  assign mis_a = vld_q && (rd_a != exp_a_q);
  assign mis_b = vld_q && (rd_b != exp_b_q);
  assign mis   = mis_a | mis_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= 1'b0;
      exp_a_q   <= '0;
      exp_b_q   <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      sticky    <= 1'b0;
      fail_addr <= '0;
    end else begin
      vld_q <= issue;
      if (issue) begin
        exp_a_q  <= exp_a;
        exp_b_q  <= exp_b;
        addr_a_q <= addr_a;
        addr_b_q <= addr_b;
      end
      if (clr) begin
        sticky    <= 1'b0;
        fail_addr <= '0;
      end else if (mis && !sticky) begin
        // Port A wins a same-cycle double mismatch.
        sticky    <= 1'b1;
        fail_addr <= mis_a ? addr_a_q : addr_b_q;
      end
    end
  end
endmodule

// File: rtl/tdp_bram_bist.sv
// Cross-port march BIST for a true-dual-port BRAM: even/odd split writes, swapped read-back, true then inverted pass.
module tdp_bram_bist
  import tdp_bist_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ABITS-1:0] fail_addr,
  tdp_bram_bist_if.master  ram
);
  localparam int IW = ABITS - 1;

  state_t           state_q;
  logic             p_q;
  logic [IW-1:0]    idx_q;
  logic             last, accept, mis, sticky;
  logic [ABITS-1:0] even_addr, odd_addr;
  logic [DBITS-1:0] pat_even, pat_odd;

  assign last      = &idx_q;
  assign accept    = (state_q == IDLE) && start;
  assign even_addr = {idx_q, 1'b0};
  assign odd_addr  = {idx_q, 1'b1};
  assign pat_even  = DBITS'(pat(PAT_MAX_A'(even_addr), p_q, ABITS, DBITS));
  assign pat_odd   = DBITS'(pat(PAT_MAX_A'(odd_addr), p_q, ABITS, DBITS));
  assign busy      = (state_q == WR) || (state_q == RD) || (state_q == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= 1'b0;
      idx_q   <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= WR;
          p_q     <= 1'b0;
          idx_q   <= '0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
        WR: begin
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= RD;
        end
        RD: begin
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!p_q) begin
            state_q <= WR;
            p_q     <= 1'b1;
          end else begin
            // The final read compares this cycle, so fold its result in directly.
            state_q <= DONE;
            done    <= 1'b1;
            pass    <= !(sticky | mis);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram.a_a  = '0;
    ram.a_b  = '0;
    ram.wd_a = '0;
    ram.wd_b = '0;
    ram.we_a = 1'b0;
    ram.we_b = 1'b0;
    case (state_q)
      WR: begin
        ram.a_a  = even_addr;
        ram.a_b  = odd_addr;
        ram.wd_a = pat_even;
        ram.wd_b = pat_odd;
        ram.we_a = 1'b1;
        ram.we_b = 1'b1;
      end
      RD: begin
        ram.a_a = odd_addr;
        ram.a_b = even_addr;
      end
      default: ;
    endcase
  end

  tdp_bist_checker #(.ABITS(ABITS), .DBITS(DBITS)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .issue     (state_q == RD),
    .exp_a     (pat_odd),
    .addr_a    (odd_addr),
    .exp_b     (pat_even),
    .addr_b    (even_addr),
    .rd_a      (ram.rd_a),
    .rd_b      (ram.rd_b),
    .mis       (mis),
    .sticky    (sticky),
    .fail_addr (fail_addr)
  );
endmodule

// File: tb/tb_tdp_bram_bist.sv
// Self-checking bench: BIST against an ideal/faulty TDP RAM model, with a scoreboard of expected run results.
module tb_tdp_bram_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start36 = 1'b0;
  logic busy, done, pass, busy36, done36, pass36;
  logic [3:0] fail_addr, fail_addr36;
  logic mem_clr = 1'b0;
  int fault = 0;
  int n_chk = 0;
  int n_fail = 0;
  int coll = 0;

  typedef struct { logic pass; logic [3:0] addr; int cyc; } res_t;
  typedef struct { logic [3:0] addr; logic [35:0] data; } wr_t;
  res_t exp_q[$];
  wr_t  wq[$];

  always #5 clk = ~clk;

  tdp_bram_bist_if #(.ABITS(4), .DBITS(8))  bus();
  tdp_bram_bist_if #(.ABITS(4), .DBITS(36)) bus36();

  tdp_bram_bist #(.ABITS(4), .DBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .ram(bus));

  tdp_bram_bist #(.ABITS(4), .DBITS(36)) dut36 (
    .clk(clk), .rst_n(rst_n), .start(start36), .busy(busy36), .done(done36),
    .pass(pass36), .fail_addr(fail_addr36), .ram(bus36));

  // RAM model: fault 1 = bit0 stuck-at-1 at addr 5, fault 2 = port-B writes dropped.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (bus.we_a) mem[bus.a_a] <= bus.wd_a;
      if (bus.we_b && fault != 2) mem[bus.a_b] <= bus.wd_b;
    end
    bus.rd_a <= mem[bus.a_a] | ((fault == 1 && bus.a_a == 4'd5) ? 8'h01 : 8'h00);
    bus.rd_b <= mem[bus.a_b] | ((fault == 1 && bus.a_b == 4'd5) ? 8'h01 : 8'h00);
  end

  logic [35:0] mem36 [16];
  always @(posedge clk) begin
    if (bus36.we_a) mem36[bus36.a_a] <= bus36.wd_a;
    if (bus36.we_b) mem36[bus36.a_b] <= bus36.wd_b;
    bus36.rd_a <= mem36[bus36.a_a];
    bus36.rd_b <= mem36[bus36.a_b];
  end

  always @(negedge clk)
    if (bus.we_a && bus.we_b && bus.a_a == bus.a_b) coll++;

  task automatic clear_mem(input int f);
    @(negedge clk);
    fault = f;
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask

  // Pulses start from IDLE and counts busy cycles until done; spam keeps start high throughout.
  task automatic go_and_wait(input bit spam, output int bcyc, output bit to);
    bcyc = 0;
    to = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!spam) start = 1'b0;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) bcyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass); end
    n_chk++; if (fail_addr !== 4'd0) begin n_fail++; $display("FAIL reset_fail_addr got %0d want 0", fail_addr); end
    n_chk++; if ({bus.we_a, bus.we_b} !== 2'b00) begin n_fail++; $display("FAIL reset_we got %b want 00", {bus.we_a, bus.we_b}); end
    n_chk++; if ({bus.a_a, bus.a_b, bus.wd_a, bus.wd_b} !== 24'h0) begin n_fail++; $display("FAIL reset_bus got %h want 0", {bus.a_a, bus.a_b, bus.wd_a, bus.wd_b}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_and_score(input string nm, input int f, input logic ep, input logic [3:0] ea, input bit spam);
    int bc; bit to; res_t e;
    clear_mem(f);
    exp_q.push_back('{pass: ep, addr: ea, cyc: 34});
    go_and_wait(spam, bc, to);
    e = exp_q.pop_front();
    n_chk++; if (to) begin n_fail++; $display("FAIL %s_timeout done never rose", nm); end
    n_chk++; if (bc != e.cyc) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, bc, e.cyc); end
    n_chk++; if (pass !== e.pass) begin n_fail++; $display("FAIL %s_pass got %b want %b", nm, pass, e.pass); end
    n_chk++; if (fail_addr !== e.addr) begin n_fail++; $display("FAIL %s_fail_addr got %0d want %0d", nm, fail_addr, e.addr); end
  endtask

  task automatic test_ideal;
    coll = 0;
    run_and_score("ideal", 0, 1'b1, 4'd0, 1'b0);
    n_chk++; if (coll != 0) begin n_fail++; $display("FAIL ideal_collision got %0d want 0", coll); end
  endtask

  task automatic test_stuck;
    run_and_score("stuck", 1, 1'b0, 4'd5, 1'b0);
  endtask

  task automatic test_drop_b;
    run_and_score("dropb", 2, 1'b0, 4'd1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int bc; bit to;
    run_and_score("spam", 0, 1'b1, 4'd0, 1'b1);
    // Now in DONE: a start here must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL start_in_done got busy,done=%b want 01", {busy, done}); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL restart got busy,done=%b want 10", {busy, done}); end
    bc = 1;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
      if (busy) bc++;
    end
    n_chk++; if (to || bc != 34) begin n_fail++; $display("FAIL restart_busy_cycles got %0d want 34 (timeout=%0b)", bc, to); end
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass got %b want 1", pass); end
  endtask

  task automatic test_reset_mid;
    clear_mem(0);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_chk++; if ({busy, bus.we_a} !== 2'b11) begin n_fail++; $display("FAIL midwr_active got busy,we_a=%b want 11", {busy, bus.we_a}); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, done, bus.we_a, bus.we_b} !== 4'b0000) begin n_fail++; $display("FAIL midrst got busy,done,we_a,we_b=%b want 0000", {busy, done, bus.we_a, bus.we_b}); end
    n_chk++; if ({bus.a_a, bus.a_b} !== 8'h00) begin n_fail++; $display("FAIL midrst_addr got %h want 00", {bus.a_a, bus.a_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    run_and_score("postrst", 0, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic test_pattern36;
    wr_t w;
    bit to;
    wq.push_back('{addr: 4'd2, data: 36'h222222222});
    wq.push_back('{addr: 4'd3, data: 36'h333333333});
    wq.push_back('{addr: 4'd2, data: 36'hDDDDDDDDD});
    wq.push_back('{addr: 4'd3, data: 36'hCCCCCCCCC});
    @(negedge clk);
    start36 = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start36 = 1'b0;
      if (done36) begin to = 1'b0; break; end
      if (bus36.we_a && bus36.a_a == 4'd2) begin
        n_chk++;
        if (wq.size() == 0) begin n_fail++; $display("FAIL p36_extra_write_a addr 2 data %h", bus36.wd_a); end
        else begin
          w = wq.pop_front();
          if (w.addr != 4'd2 || bus36.wd_a !== w.data) begin n_fail++; $display("FAIL p36_wd_a got %h want %h (addr %0d)", bus36.wd_a, w.data, w.addr); end
        end
      end
      if (bus36.we_b && bus36.a_b == 4'd3) begin
        n_chk++;
        if (wq.size() == 0) begin n_fail++; $display("FAIL p36_extra_write_b addr 3 data %h", bus36.wd_b); end
        else begin
          w = wq.pop_front();
          if (w.addr != 4'd3 || bus36.wd_b !== w.data) begin n_fail++; $display("FAIL p36_wd_b got %h want %h (addr %0d)", bus36.wd_b, w.data, w.addr); end
        end
      end
    end
    n_chk++; if (to || wq.size() != 0) begin n_fail++; $display("FAIL p36_complete got pending=%0d timeout=%0b want 0,0", wq.size(), to); end
    n_chk++; if ({pass36, fail_addr36} !== 5'b1_0000) begin n_fail++; $display("FAIL p36_result got pass=%b addr=%0d want pass=1 addr=0", pass36, fail_addr36); end
    wq.delete();
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck();
    test_drop_b();
    test_back_to_back();
    test_reset_mid();
    test_pattern36();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
